// File: rtl/refill_arbiter.sv
// Shares one AXI-style burst read channel between the icache and dcache refill ports.
// Bursts are LINE_BEATS x 32-bit INCR reads, packed into one line returned to the granted side.
module refill_arbiter #(
    parameter int unsigned LINE_BEATS = 4,
    parameter int unsigned ARLEN_VAL  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    // icache refill port
    input  logic                     i_ren,
    input  logic [31:0]              i_raddr,
    output logic                     i_rrdy,
    output logic                     i_ren_received,
    output logic                     i_rvalid,
    output logic [LINE_BEATS*32-1:0] i_rdata,
    output logic                     i_flush_flag_valid,
    // dcache refill port
    input  logic                     d_ren,
    input  logic [31:0]              d_raddr,
    output logic                     d_rrdy,
    output logic                     d_ren_received,
    output logic                     d_rvalid,
    output logic [LINE_BEATS*32-1:0] d_rdata,
    // AXI read address channel
    output logic [31:0]              araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,
    // AXI read data channel
    input  logic [31:0]              rdata,
    input  logic                     rvalid,
    input  logic                     rlast,
    output logic                     rready
);

    localparam int unsigned LINE_W = LINE_BEATS * 32;
    localparam int unsigned BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(LINE_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        AR    = 2'd1,
        RDATA = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q, state_nxt;
    logic                grant_d_q, grant_d_nxt;
    logic                last_d_q, last_d_nxt;
    logic [BEAT_W-1:0]   beat_q, beat_nxt;
    logic [LINE_W-1:0]   line_q, line_nxt, line_wr;
    logic                rrdy_q, rrdy_nxt;
    logic                pick_d;

    logic [31:0]         araddr_nxt;
    logic                arvalid_nxt, rready_nxt;
    logic                i_rec_nxt, d_rec_nxt, i_rv_nxt, d_rv_nxt, i_flush_nxt;
    logic [LINE_W-1:0]   i_rdata_nxt, d_rdata_nxt;

    assign arlen   = 8'(ARLEN_VAL);
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign i_rrdy  = rrdy_q;
    assign d_rrdy  = rrdy_q;

    // Current line with the incoming beat dropped into its slot (slot saturates at the top).
    always_comb begin
        line_wr = line_q;
        for (int k = 0; k < int'(LINE_BEATS); k++) begin
            if (beat_q == BEAT_W'(k)) begin
                line_wr[32*k +: 32] = rdata;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state_q;
        grant_d_nxt = grant_d_q;
        last_d_nxt  = last_d_q;
        beat_nxt    = beat_q;
        line_nxt    = line_q;
        araddr_nxt  = araddr;
        arvalid_nxt = arvalid;
        rready_nxt  = rready;
        i_rec_nxt   = 1'b0;
        d_rec_nxt   = 1'b0;
        i_rv_nxt    = 1'b0;
        d_rv_nxt    = 1'b0;
        i_rdata_nxt = i_rdata;
        d_rdata_nxt = d_rdata;
        i_flush_nxt = i_flush_flag_valid;
        pick_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_ren || d_ren) begin
                    // Round-robin on a tie: favour the side that did not win last time.
                    pick_d      = d_ren && (!i_ren || !last_d_q);
                    grant_d_nxt = pick_d;
                    last_d_nxt  = pick_d;
                    araddr_nxt  = pick_d ? d_raddr : i_raddr;
                    arvalid_nxt = 1'b1;
                    line_nxt    = '0;
                    state_nxt   = AR;
                end
            end
            AR: begin
                if (arvalid && arready) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    beat_nxt    = '0;
                    i_rec_nxt   = !grant_d_q;
                    d_rec_nxt   = grant_d_q;
                    if (!grant_d_q) begin
                        i_flush_nxt = 1'b1;
                    end
                    state_nxt   = RDATA;
                end
            end
            RDATA: begin
                if (rvalid && rready) begin
                    line_nxt = line_wr;
                    beat_nxt = (beat_q == BEAT_MAX) ? beat_q : beat_q + BEAT_W'(1);
                    if (rlast) begin
                        rready_nxt = 1'b0;
                        state_nxt  = RESP;
                        if (grant_d_q) begin
                            d_rv_nxt    = 1'b1;
                            d_rdata_nxt = line_wr;
                        end else begin
                            i_rv_nxt    = 1'b1;
                            i_rdata_nxt = line_wr;
                            i_flush_nxt = 1'b0;
                        end
                    end
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        rrdy_nxt = (state_nxt == IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q            <= IDLE;
            grant_d_q          <= 1'b0;
            last_d_q           <= 1'b1;
            beat_q             <= '0;
            line_q             <= '0;
            rrdy_q             <= 1'b1;
            araddr             <= '0;
            arvalid            <= 1'b0;
            rready             <= 1'b0;
            i_ren_received     <= 1'b0;
            d_ren_received     <= 1'b0;
            i_rvalid           <= 1'b0;
            d_rvalid           <= 1'b0;
            i_rdata            <= '0;
            d_rdata            <= '0;
            i_flush_flag_valid <= 1'b0;
        end else begin
            state_q            <= state_nxt;
            grant_d_q          <= grant_d_nxt;
            last_d_q           <= last_d_nxt;
            beat_q             <= beat_nxt;
            line_q             <= line_nxt;
            rrdy_q             <= rrdy_nxt;
            araddr             <= araddr_nxt;
            arvalid            <= arvalid_nxt;
            rready             <= rready_nxt;
            i_ren_received     <= i_rec_nxt;
            d_ren_received     <= d_rec_nxt;
            i_rvalid           <= i_rv_nxt;
            d_rvalid           <= d_rv_nxt;
            i_rdata            <= i_rdata_nxt;
            d_rdata            <= d_rdata_nxt;
            i_flush_flag_valid <= i_flush_nxt;
        end
    end

endmodule

// File: tb/tb_refill_arbiter.sv
// Randomized bench for refill_arbiter: transaction-timeline reference model checked every cycle,
// plus directed scenarios with hand-computed line and grant expectations.
module tb_refill_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_ren = 1'b0, d_ren = 1'b0;
    logic [31:0]  i_raddr = '0, d_raddr = '0;
    logic         i_rrdy, d_rrdy, i_ren_received, d_ren_received;
    logic         i_rvalid, d_rvalid, i_flush_flag_valid;
    logic [127:0] i_rdata, d_rdata;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid, rready;
    logic         arready = 1'b0;
    logic [31:0]  rdata = '0;
    logic         rvalid = 1'b0, rlast = 1'b0;

    refill_arbiter dut (
        .clk(clk), .rst(rst),
        .i_ren(i_ren), .i_raddr(i_raddr), .i_rrdy(i_rrdy), .i_ren_received(i_ren_received),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_flush_flag_valid(i_flush_flag_valid),
        .d_ren(d_ren), .d_raddr(d_raddr), .d_rrdy(d_rrdy), .d_ren_received(d_ren_received),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- reference model: one refill transaction as a timeline ----------------
    bit           m_txn = 0, m_side = 0, m_wait_ar = 0, m_resp = 0, m_last_d = 1;
    int           m_nb = 0;
    logic [127:0] m_line = '0;
    logic         e_rrdy = 1, e_arvalid = 0, e_rready = 0;
    logic [31:0]  e_araddr = '0;
    logic         e_rec_i = 0, e_rec_d = 0, e_rv_i = 0, e_rv_d = 0, e_flush = 0;
    logic [127:0] e_rdata_i = '0, e_rdata_d = '0;

    task model_step();
        int slot;
        if (!rst) begin
            m_txn = 0; m_wait_ar = 0; m_resp = 0; m_last_d = 1; m_nb = 0; m_line = '0;
            e_rrdy = 1; e_arvalid = 0; e_rready = 0; e_araddr = '0;
            e_rec_i = 0; e_rec_d = 0; e_rv_i = 0; e_rv_d = 0; e_flush = 0;
            e_rdata_i = '0; e_rdata_d = '0;
            return;
        end
        e_rec_i = 0; e_rec_d = 0; e_rv_i = 0; e_rv_d = 0;
        if (m_resp) begin
            m_resp = 0; m_txn = 0; e_rrdy = 1;
        end else if (!m_txn) begin
            if (i_ren || d_ren) begin
                m_side    = (i_ren && d_ren) ? !m_last_d : d_ren;
                m_last_d  = m_side;
                e_araddr  = m_side ? d_raddr : i_raddr;
                e_arvalid = 1; e_rrdy = 0;
                m_txn = 1; m_wait_ar = 1; m_nb = 0; m_line = '0;
            end
        end else if (m_wait_ar) begin
            if (arready) begin
                e_arvalid = 0; e_rready = 1; m_wait_ar = 0;
                if (m_side) e_rec_d = 1;
                else begin e_rec_i = 1; e_flush = 1; end
            end
        end else if (rvalid && e_rready) begin
            slot = (m_nb < 3) ? m_nb : 3;
            m_line[slot*32 +: 32] = rdata;
            m_nb++;
            if (rlast) begin
                e_rready = 0; m_resp = 1;
                if (m_side) begin e_rv_d = 1; e_rdata_d = m_line; end
                else begin e_rv_i = 1; e_rdata_i = m_line; e_flush = 0; end
            end
        end
    endtask

    // Captures for directed checks
    int           cnt_irec = 0, cnt_drec = 0, cnt_irv = 0, cnt_drv = 0;
    logic [127:0] cap_i_line = '0, cap_d_line = '0;
    logic [31:0]  cap_araddr = '0;
    logic         cap_flush_at_irv = 1'b1;
    logic         arv_prev = 1'b0;
    bit           grant_log[$];

    // Per-cycle compare against the model, sampled 2 time units after the clock edge.
    always @(posedge clk) begin
        model_step();
        #2;
        chk("i_rrdy", i_rrdy, e_rrdy);
        chk("d_rrdy", d_rrdy, e_rrdy);
        chk("arvalid", arvalid, e_arvalid);
        chk("araddr", araddr, e_araddr);
        chk("rready", rready, e_rready);
        chk("i_ren_received", i_ren_received, e_rec_i);
        chk("d_ren_received", d_ren_received, e_rec_d);
        chk("i_rvalid", i_rvalid, e_rv_i);
        chk("d_rvalid", d_rvalid, e_rv_d);
        chk("i_rdata", i_rdata, e_rdata_i);
        chk("d_rdata", d_rdata, e_rdata_d);
        chk("i_flush_flag_valid", i_flush_flag_valid, e_flush);
        if (i_ren_received) begin cnt_irec++; grant_log.push_back(1'b0); end
        if (d_ren_received) begin cnt_drec++; grant_log.push_back(1'b1); end
        if (i_rvalid) begin cnt_irv++; cap_i_line = i_rdata; cap_flush_at_irv = i_flush_flag_valid; end
        if (d_rvalid) begin cnt_drv++; cap_d_line = d_rdata; end
        if (arvalid && !arv_prev) cap_araddr = araddr;
        arv_prev = arvalid;
    end

    // Requesters hold ren until their address is accepted.
    always @(negedge clk) begin
        if (i_ren_received) i_ren = 1'b0;
        if (d_ren_received) d_ren = 1'b0;
    end

    // ---------------- AXI slave ----------------
    int          cfg_ar_delay = -1;
    int          cfg_gap = -1;
    logic [31:0] cfg_beats[$];
    int          beats_sent = 0;
    bit          slave_busy = 0;

    initial begin
        logic [31:0] beats[$];
        int dly;
        int gap;
        forever begin
            @(negedge clk);
            if (arvalid && rst) begin
                slave_busy = 1;
                dly = (cfg_ar_delay >= 0) ? cfg_ar_delay : int'($urandom_range(0, 4));
                repeat (dly) @(negedge clk);
                arready = 1'b1;
                @(negedge clk);
                arready = 1'b0;
                beats.delete();
                if (cfg_beats.size() == 0) begin
                    for (int k = 0; k < int'($urandom_range(1, 6)); k++) beats.push_back($urandom);
                end else begin
                    beats = cfg_beats;
                end
                gap = cfg_gap;
                cfg_beats.delete(); cfg_ar_delay = -1; cfg_gap = -1;
                for (int k = 0; k < beats.size(); k++) begin
                    repeat ((gap >= 0) ? gap : int'($urandom_range(0, 2))) @(negedge clk);
                    rdata  = beats[k];
                    rvalid = 1'b1;
                    rlast  = (k == beats.size() - 1);
                    beats_sent++;
                    @(negedge clk);
                    rvalid = 1'b0;
                    rlast  = 1'b0;
                end
                slave_busy = 0;
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        a[3:0] = 4'h0;
        return a;
    endfunction

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while ((i_ren || d_ren || m_txn || slave_busy) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) chk("idle_timeout", 1'b1, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_beats(input int n);
        int k = 0;
        while (beats_sent < n && k < 500) begin
            @(posedge clk);
            k++;
        end
        if (k >= 500) chk("beat_timeout", 1'b1, 1'b0);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_std_beats();
        cfg_beats.delete();
        cfg_beats.push_back(32'h11); cfg_beats.push_back(32'h22);
        cfg_beats.push_back(32'h33); cfg_beats.push_back(32'h44);
    endtask

    localparam logic [127:0] STD_LINE = 128'h00000044_00000033_00000022_00000011;

    // ---------------- main sequence ----------------
    initial begin
        int snap_i, snap_d, snap_rv;
        bit g0, g1, g2, g3;

        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_arlen", arlen, 8'd3);
        chk("reset_arsize", arsize, 3'b010);
        chk("reset_arburst", arburst, 2'b01);
        chk("reset_rrdy", i_rrdy, 1'b1);
        chk("reset_arvalid", arvalid, 1'b0);
        chk("reset_i_rdata", i_rdata, 128'h0);

        // Single icache refill
        cfg_ar_delay = 2; cfg_gap = 0; load_std_beats();
        i_raddr = 32'h1C000040; i_ren = 1'b1;
        wait_idle();
        chk("single_araddr", cap_araddr, 32'h1C000040);
        chk("single_irec_count", cnt_irec, 1);
        chk("single_irv_count", cnt_irv, 1);
        chk("single_drv_count", cnt_drv, 0);
        chk("single_line", cap_i_line, STD_LINE);

        // Simultaneous requests alternate, starting with icache after reset
        do_reset();
        grant_log.delete();
        i_raddr = rand_addr(); d_raddr = rand_addr(); i_ren = 1'b1; d_ren = 1'b1;
        wait_idle();
        i_raddr = rand_addr(); d_raddr = rand_addr(); i_ren = 1'b1; d_ren = 1'b1;
        wait_idle();
        chk("rr_log_size", grant_log.size(), 4);
        g0 = (grant_log.size() > 0) ? grant_log[0] : 1'bx;
        g1 = (grant_log.size() > 1) ? grant_log[1] : 1'bx;
        g2 = (grant_log.size() > 2) ? grant_log[2] : 1'bx;
        g3 = (grant_log.size() > 3) ? grant_log[3] : 1'bx;
        chk("rr_grant0_icache", g0, 1'b0);
        chk("rr_grant1_dcache", g1, 1'b1);
        chk("rr_grant2_icache", g2, 1'b0);
        chk("rr_grant3_dcache", g3, 1'b1);

        // Icache flush mid-burst: flag held through, cleared with the delivery pulse
        snap_i = cnt_irv;
        beats_sent = 0; cfg_gap = 3; load_std_beats();
        i_raddr = rand_addr(); i_ren = 1'b1;
        wait_beats(2);
        chk("flush_mid_burst", i_flush_flag_valid, 1'b1);
        wait_idle();
        chk("flush_irv_count", cnt_irv, snap_i + 1);
        chk("flush_clear_at_rvalid", cap_flush_at_irv, 1'b0);
        chk("flush_line", cap_i_line, STD_LINE);

        // Back-pressure on AR and R
        cfg_ar_delay = 10; cfg_gap = 2; load_std_beats();
        i_raddr = 32'h1C000040; i_ren = 1'b1;
        wait_idle();
        chk("bp_araddr", cap_araddr, 32'h1C000040);
        chk("bp_line", cap_i_line, STD_LINE);

        // Async reset in RDATA after two beats
        beats_sent = 0; cfg_gap = 3; load_std_beats();
        d_raddr = rand_addr(); d_ren = 1'b1;
        wait_beats(2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_d_rdata", d_rdata, 128'h0);
        snap_rv = cnt_irv + cnt_drv;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_idle();
        chk("rst_no_rvalid", cnt_irv + cnt_drv, snap_rv);
        snap_d = cnt_drv;
        cfg_gap = 0; load_std_beats();
        d_raddr = 32'h2000_0100; d_ren = 1'b1;
        wait_idle();
        chk("post_rst_drv_count", cnt_drv, snap_d + 1);
        chk("post_rst_line", cap_d_line, STD_LINE);

        // Early rlast on beat 2
        snap_d = cnt_drv;
        cfg_beats.delete(); cfg_beats.push_back(32'hAA); cfg_beats.push_back(32'hBB);
        d_raddr = rand_addr(); d_ren = 1'b1;
        wait_idle();
        chk("early_rlast_count", cnt_drv, snap_d + 1);
        chk("early_rlast_line", cap_d_line, 128'h00000000_00000000_000000BB_000000AA);

        // Randomized traffic against the model
        for (int it = 0; it < 150; it++) begin
            repeat ($urandom_range(1, 6)) @(negedge clk);
            if (!i_ren && $urandom_range(0, 2) != 0) begin i_raddr = rand_addr(); i_ren = 1'b1; end
            if (!d_ren && $urandom_range(0, 2) != 0) begin d_raddr = rand_addr(); d_ren = 1'b1; end
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
